// File: rtl/rom_arb_pkg.sv
// rtl/rom_arb_pkg.sv - shared constants and helpers for the ROM arbiter
package rom_arb_pkg;

    localparam int DEF_NUM_REQ    = 4;
    localparam int DEF_ADDR_WIDTH = 8;
    localparam int DEF_DATA_WIDTH = 16;
    localparam int MAX_REQ        = 8;
    localparam int MAX_IDX_W      = 3;

    // Lowest set bit wins; callers only ever pass a one-hot or all-zero vector.
    function automatic logic [MAX_IDX_W-1:0] onehot_to_idx(input logic [MAX_REQ-1:0] onehot);
        logic [MAX_IDX_W-1:0] idx;
        idx = '0;
        for (int i = MAX_REQ - 1; i >= 0; i--) begin
            if (onehot[i]) begin
                idx = MAX_IDX_W'(i);
            end
        end
        return idx;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - round-robin request arbiter owning the rotating priority pointer
module rr_arbiter
    import rom_arb_pkg::*;
#(
    parameter int NUM_REQ = DEF_NUM_REQ,
    parameter int PTR_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NUM_REQ-1:0] req,
    output logic [NUM_REQ-1:0] gnt,
    output logic [PTR_W-1:0]   gnt_idx
);

    logic [PTR_W-1:0]   rr_ptr;
    logic [MAX_REQ-1:0] gnt_ext;
    logic               found;

    // Two passes: indices at or above the pointer first, then the wrapped-around low indices.
    always_comb begin
        gnt   = '0;
        found = 1'b0;
        if (!rst) begin
            for (int i = 0; i < NUM_REQ; i++) begin
                if (!found && req[i] && (i >= int'(rr_ptr))) begin
                    gnt[i] = 1'b1;
                    found  = 1'b1;
                end
            end
            for (int i = 0; i < NUM_REQ; i++) begin
                if (!found && req[i]) begin
                    gnt[i] = 1'b1;
                    found  = 1'b1;
                end
            end
        end
    end

    always_comb begin
        gnt_ext              = '0;
        gnt_ext[NUM_REQ-1:0] = gnt;
        gnt_idx              = PTR_W'(onehot_to_idx(gnt_ext));
    end

    // Explicit wrap compare keeps non-power-of-two requester counts correct.
    always_ff @(posedge clk) begin
        if (rst) begin
            rr_ptr <= '0;
        end else if (|gnt) begin
            if (gnt_idx == PTR_W'(NUM_REQ - 1)) begin
                rr_ptr <= '0;
            end else begin
                rr_ptr <= gnt_idx + PTR_W'(1);
            end
        end
    end

endmodule

// File: rtl/rom_arbiter.sv
// rtl/rom_arbiter.sv - shares one registered-read ROM between several requesters
module rom_arbiter
    import rom_arb_pkg::*;
#(
    parameter int NUM_REQ    = DEF_NUM_REQ,
    parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
    parameter int DATA_WIDTH = DEF_DATA_WIDTH
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [NUM_REQ-1:0]            req,
    input  logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr,
    output logic [NUM_REQ-1:0]            gnt,
    output logic [NUM_REQ-1:0]            rsp_valid,
    output logic [DATA_WIDTH-1:0]         rsp_data,
    output logic [ADDR_WIDTH-1:0]         rom_addr,
    input  logic [DATA_WIDTH-1:0]         rom_q,
    output logic                          busy
);

    localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    logic [PTR_W-1:0]      gnt_idx;
    logic                  transfer;
    logic [ADDR_WIDTH-1:0] issue_addr;

    logic                  s1_valid;
    logic [NUM_REQ-1:0]    s1_tag;
    logic                  s2_valid;
    logic [NUM_REQ-1:0]    s2_tag;

    rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .PTR_W   (PTR_W)
    ) u_rr_arbiter (
        .clk     (clk),
        .rst     (rst),
        .req     (req),
        .gnt     (gnt),
        .gnt_idx (gnt_idx)
    );

    assign transfer = |(req & gnt);

    always_comb begin
        issue_addr = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (gnt_idx == PTR_W'(i)) begin
                issue_addr = req_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
            end
        end
    end

    // Stage 1 carries the address into the ROM, stage 2 lines the tag up with rom_q.
    always_ff @(posedge clk) begin
        if (rst) begin
            rom_addr <= '0;
            s1_valid <= 1'b0;
            s1_tag   <= '0;
            s2_valid <= 1'b0;
            s2_tag   <= '0;
        end else begin
            s1_valid <= transfer;
            if (transfer) begin
                rom_addr <= issue_addr;
                s1_tag   <= gnt;
            end
            s2_valid <= s1_valid;
            s2_tag   <= s1_tag;
        end
    end

    assign rsp_valid = s2_valid ? s2_tag : '0;
    assign rsp_data  = rom_q;
    assign busy      = s1_valid | s2_valid;

endmodule

// File: doc/rom_arbiter.md
Name: rom_arbiter

Overview:
- Shares one synchronous, single-port lookup ROM (1-cycle registered read) between NUM_REQ independent requesters.
- Round-robin arbitration.
- Issues at most one read per cycle, fully pipelined.
- Routes each returned word back to the requester that issued it.
- Sits between the client blocks and the ROM instance. It drives the ROM address and consumes the ROM's q output.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- ADDR_WIDTH, 8, ROM address width.
- DATA_WIDTH, 16, ROM word width.

Ports:
- clk  input  1  system clock, all logic on posedge.
- rst  input  1  synchronous, active-high reset.
- req  input  NUM_REQ  per-requester read request. Held high with address stable until granted.
- req_addr  input  NUM_REQ*ADDR_WIDTH  flattened addresses. Requester i uses bits [i*ADDR_WIDTH +: ADDR_WIDTH].
- gnt  output  NUM_REQ  one-hot, combinational. Transfer occurs at a posedge where req[i]&gnt[i].
- rsp_valid  output  NUM_REQ  one-hot, registered. Pulses for one cycle when rsp_data belongs to requester i.
- rsp_data  output  DATA_WIDTH  broadcast read data (wired from rom_q).
- rom_addr  output  ADDR_WIDTH  registered address to the ROM.
- rom_q  input  DATA_WIDTH  ROM read data, valid one cycle after rom_addr is sampled.
- busy  output  1  high while any read is in flight (stage1 or stage2 valid).

Behaviour:
- Reset, synchronous: rr_ptr=0, rom_addr=0, stage1/stage2 valid=0, tags=0. Therefore rsp_valid=0 and busy=0.
- Arbitration (combinational):
  - Search req starting at index rr_ptr, ascending with wrap to 0.
  - First asserted index w gets gnt[w]=1; all others 0.
  - No req asserted → gnt=0.
  - gnt never asserted during rst.
- Pointer: on a cycle with a grant to w, rr_ptr <= (w+1) mod NUM_REQ. No grant → rr_ptr holds.
- Issue, edge E0 (transfer): rom_addr <= req_addr[w]; s1_valid <= 1; s1_tag <= one-hot w. No transfer → s1_valid <= 0, rom_addr holds.
- ROM read, edge E1: ROM samples rom_addr. s2_valid <= s1_valid; s2_tag <= s1_tag.
- Response: after E1, rsp_valid = s2_valid ? s2_tag : 0, coincident with rom_q. Latency is 2 edges from handshake edge to data visible.
- Throughput: one transfer per cycle, back-to-back, no bubbles. No backpressure on responses; requesters must accept rsp_valid when it pulses.
- Requester rule: deassert req (or present a new address) in the cycle after the handshake. A req still high is treated as a new request.
- Fairness: a continuously asserted req is granted within NUM_REQ cycles.
- Simultaneous requests: resolved purely by rr_ptr. Order of grants equals order of responses.
- Response concurrent with new grant: independent; both occur in the same cycle.
- Reset mid-operation: in-flight reads are dropped. No rsp_valid in the cycle after rst is sampled. rr_ptr returns to 0.
- Addresses are used as-is with no range checking. Full 2**ADDR_WIDTH space.
- Width rules: rr_ptr is $clog2(NUM_REQ) bits. Wrap uses explicit compare to NUM_REQ-1, not overflow, so non-power-of-2 NUM_REQ works.

Decomposition:
- Package rom_arb_pkg:
  - function onehot_to_idx.
  - localparam PTR_W = $clog2(NUM_REQ) (or computed in-module if the package stays parameter-free).
  - Default width constants.
- Sub-module rr_arbiter (params NUM_REQ):
  - inputs clk, rst, req.
  - outputs gnt (combinational), gnt_idx.
  - owns rr_ptr.
- rom_arbiter instantiates rr_arbiter and holds the issue/response pipeline. The ROM itself is instantiated by the parent, not inside.

Test Plan:
- Reset check: assert rst 2 cycles with req=4'b1111 → gnt=0, rsp_valid=0, busy=0, rom_addr=0 throughout.
- Single read: ROM preloaded with rom[i]=16'hA000+i. req[2]=1, addr 8'h15 for one cycle → gnt=4'b0100 that cycle; rsp_valid=4'b0100 and rsp_data=16'hA015 two edges later, one cycle wide.
- Round-robin: req=4'b1111 held, addrs 1..4 → gnt sequence 0001,0010,0100,1000,0001. rsp_valid follows the same sequence 2 cycles later with data A001..A004. No gaps.
- Wrap/fairness: rr_ptr=3 (after granting 2), req=4'b1001 → gnt=4'b1000, then 4'b0001. Requester 0 is never skipped more than NUM_REQ-1 cycles.
- Reset mid-flight: two reads issued at consecutive edges, rst asserted on the next edge → no rsp_valid afterwards. After release, first grant with req=4'b0110 goes to index 1.
- Idle gap: grant, 3 idle cycles, grant → s1_valid drops during idle, rom_addr holds last value, busy falls 2 cycles after last issue.
